// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dual-port data memory.
package dmem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_ADDR_W = 8;

  // Even parity bit; callers zero-extend, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dmem_clear_fsm.sv
// Clear sequencer: walks every address once, owning the array write port while busy.
module dmem_clear_fsm
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q == CLEAR);
    o_clr_we   = (state_q == CLEAR);
    o_clr_addr = cnt_q;
  end

endmodule

// File: rtl/data_memory_dp.sv
// Dual-port data memory with registered, write-first read and a hardware clear.
// Optional stored even parity per word when DMEM_PARITY_EN is defined.
module data_memory_dp
  import dmem_pkg::*;
#(
  parameter int                 DATA_W    = DMEM_DATA_W,
  parameter int                 ADDR_W    = DMEM_ADDR_W,
  parameter int                 DEPTH     = 2**ADDR_W,
  parameter string              INIT_FILE = "",
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_address_wr,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_address_rd,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_parity_err
);

`ifdef DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DMEM_PARITY_EN
    return {even_parity(64'(d)), d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              busy, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_user, wr_en, rd_en, rd_in_range, fwd;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_data, rd_word;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  dmem_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_fsm (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .o_busy     (busy),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  // Clear sequencer has priority; user accesses are locked out while busy.
  always_comb begin
    wr_user     = i_wr && !busy && ({1'b0, i_address_wr} < DEPTH_X);
    wr_en       = clr_we || wr_user;
    wr_addr     = clr_we ? clr_addr : i_address_wr;
    wr_data     = encode(clr_we ? CLEAR_VAL : i_din);
    rd_en       = i_rd && !busy;
    rd_in_range = ({1'b0, i_address_rd} < DEPTH_X);
    fwd         = wr_user && (i_address_wr == i_address_rd);
    rd_word     = mem_q[i_address_rd];
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (rd_en) begin
      valid_d = 1'b1;
      if (!rd_in_range) dout_d = '0;
      else if (fwd)     dout_d = i_din;
      else              dout_d = rd_word[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

`ifdef DMEM_PARITY_EN
  logic perr_q, perr_d;

  // Forwarded data never touched the array, so it is never flagged.
  always_comb begin
    perr_d = 1'b0;
    if (rd_en && rd_in_range && !fwd)
      perr_d = (even_parity(64'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_busy       = busy;
  assign o_dout       = dout_q;
  assign o_dout_valid = valid_q;

endmodule

// File: tb/tb_data_memory_dp.sv
// Randomized self-checking bench for data_memory_dp against an array reference model.
module tb_data_memory_dp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              busy;
  logic              wr;
  logic [ADDR_W-1:0] aw;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic [ADDR_W-1:0] ar;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;

  int checks   = 0;
  int failures = 0;
  int model [DEPTH];
  int exp_dout;
  int exp_valid;

  data_memory_dp #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .CLEAR_VAL (8'h00)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clear      (clear),
    .o_busy       (busy),
    .i_wr         (wr),
    .i_address_wr (aw),
    .i_din        (din),
    .i_rd         (rd),
    .i_address_rd (ar),
    .o_dout       (dout),
    .o_dout_valid (dvalid),
    .o_parity_err (perr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clear = 1'b0; wr = 1'b0; rd = 1'b0; aw = '0; ar = '0; din = '0;
  endtask

  task automatic do_write(input int a, input int d);
    quiet(); wr = 1'b1; aw = ADDR_W'(a); din = DATA_W'(d);
    step();
    model[a] = d;
    wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input int a);
    quiet(); rd = 1'b1; ar = ADDR_W'(a);
    step();
    rd = 1'b0;
    check_eq({tag, "_valid"}, 32'(dvalid), 32'd1);
    check_eq({tag, "_dout"}, 32'(dout), 32'(model[a]));
    check_eq({tag, "_perr"}, 32'(perr), 32'd0);
    exp_dout = model[a];
  endtask

  initial begin
    int n;
    quiet();
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    #1;
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_valid", 32'(dvalid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_perr", 32'(perr), 32'd0);

    // first read after reset: contents unknown, only the strobe is defined
    @(negedge clk);
    rd = 1'b1; ar = 8'h10;
    step();
    rd = 1'b0;
    check_eq("first_rd_valid", 32'(dvalid), 32'd1);
    step();
    check_eq("no_rd_valid", 32'(dvalid), 32'd0);

    do_write(8'h20, 8'hA5);
    do_read("wr_then_rd", 8'h20);
    check_eq("wr_then_rd_a5", 32'(dout), 32'hA5);

    do_write(8'h40, 8'h11);
    quiet(); wr = 1'b1; aw = 8'h40; din = 8'h3C; rd = 1'b1; ar = 8'h40;
    step();
    model[8'h40] = 8'h3C;
    check_eq("fwd_valid", 32'(dvalid), 32'd1);
    check_eq("fwd_dout", 32'(dout), 32'h3C);
    do_read("fwd_stored", 8'h40);

    // full clear with user traffic and a stray clear request thrown at it
    do_write(8'hFF, 8'h77);
    quiet(); clear = 1'b1;
    step();
    n = 0;
    while (busy && n < 1000) begin
      clear = (n == 100);
      wr = 1'b1; aw = ADDR_W'($urandom); din = DATA_W'($urandom | 1);
      rd = 1'b1; ar = ADDR_W'($urandom);
      n++;
      step();
      if (busy) check_eq("clr_no_valid", 32'(dvalid), 32'd0);
    end
    quiet();
    check_eq("clr_busy_cycles", 32'(n), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) model[a] = 0;
    do_read("clr_rd00", 8'h00);
    do_read("clr_rdff", 8'hFF);
    for (int a = 0; a < DEPTH; a++) do_read("clr_all", a);

    // randomized traffic, addresses biased low to force collisions
    for (int i = 0; i < 500; i++) begin
      int a_w, a_r, d;
      logic w, r;
      w   = 1'($urandom);
      r   = 1'($urandom);
      a_w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
      a_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
      d   = int'($urandom_range(0, 255));
      wr = w; aw = ADDR_W'(a_w); din = DATA_W'(d);
      rd = r; ar = ADDR_W'(a_r);
      exp_valid = r ? 1 : 0;
      if (r) exp_dout = (w && a_w == a_r) ? d : model[a_r];
      if (w) model[a_w] = d;
      step();
      check_eq("rnd_valid", 32'(dvalid), 32'(exp_valid));
      check_eq("rnd_dout", 32'(dout), 32'(exp_dout));
      check_eq("rnd_perr", 32'(perr), 32'd0);
    end
    quiet();

    // reset during clear cycle 10 aborts after words 0..9
    for (int a = 0; a < 16; a++) do_write(a, (a * 7 + 1) & 8'hFF);
    quiet(); clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 10; a++) model[a] = 0;
    step();
    check_eq("abort_idle", 32'(busy), 32'd0);
    for (int a = 0; a < 16; a++) do_read("abort_rd", a);
    check_eq("abort_w12", 32'(dout), 32'(model[15]));
    do_read("abort_rd12", 12);
    check_eq("abort_w12_val", 32'(dout), 32'd85);

`ifdef DMEM_PARITY_EN
    do_write(5, 8'h5B);
    do_write(6, 8'h5B);
    dut.mem_q[5][DATA_W] = ~dut.mem_q[5][DATA_W];
    quiet(); rd = 1'b1; ar = 8'h05;
    step();
    check_eq("par_bad_valid", 32'(dvalid), 32'd1);
    check_eq("par_bad_err", 32'(perr), 32'd1);
    do_read("par_clean", 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
